num_text_responder: RTL and testbench

NUM_TEXT_RESPONDER -- requirements
Module: num_text_responder

---
 rtl/num_text_responder.sv | 166 ++++++++++++++++
 tb/tb_num_text_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/num_text_responder.sv
`default_nettype none
// ============================================================================
// Module   : num_text_responder
// Purpose  : Loads a 14-bit binary value, converts it to four decimal glyph
//            codes by sequential double-dabble, and serves registered 8-pixel
//            glyph rows to a character-cell drawing stage.
// Ports    : clk          rising-edge system clock
//            rst          asynchronous, active-low reset
//            value        unsigned number to display
//            value_valid  value presented for loading
//            value_ready  block can accept a new value (IDLE only)
//            char_xy      character address, [7:4] row, [3:0] column
//            char_line    glyph row 0..15 within the character
//            char_pixel   glyph row bitmap, bit 7 leftmost, 1-clock latency
// Revision : 1.0 - initial release
// ============================================================================
module num_text_responder #(
   parameter logic [3:0] ROW        = 4'd0,
   parameter logic [3:0] COL0       = 4'd0,
   parameter logic       LEAD_BLANK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] value,
   input  logic        value_valid,
   output logic        value_ready,
   input  logic [7:0]  char_xy,
   input  logic [3:0]  char_line,
   output logic [7:0]  char_pixel
);

   localparam logic [3:0] CODE_BLANK = 4'd10;
   localparam logic [3:0] CODE_DASH  = 4'd11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [13:0] bin;
   logic [15:0] bcd;
   logic [15:0] bcd_adj;
   logic [3:0]  iter;
   logic        over;
   logic        accept;
   logic [3:0]  dig         [4];   // index 0 = most-significant digit
   logic [3:0]  commit_code [4];

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next  = state;
      value_ready = 1'b0;
      case (state)
         IDLE: begin
            value_ready = 1'b1;
            if (value_valid) state_next = SHIFT;
         end
         SHIFT:   if (iter == 4'd13) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign accept = (state == IDLE) && value_valid;

   // ---------------- double-dabble datapath ----------------
   always_comb begin
      bcd_adj = bcd;
      for (int n = 0; n < 4; n++) begin
         if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin  <= '0;
         bcd  <= '0;
         iter <= '0;
         over <= 1'b0;
      end else if (accept) begin
         bin  <= value;
         bcd  <= '0;
         iter <= '0;
         over <= (value > 14'd9999);
      end else if (state == SHIFT) begin
         bcd  <= {bcd_adj[14:0], bin[13]};
         bin  <= {bin[12:0], 1'b0};
         // Last increment is 13->14; the counter is frozen outside SHIFT.
         iter <= iter + 4'd1;
      end
   end

   // Leading-zero blanking propagates from the MSD down; the LSD is never blanked.
   always_comb begin
      logic z0, z1, z2;
      z0 = LEAD_BLANK && (bcd[15:12] == 4'd0);
      z1 = z0 && (bcd[11:8] == 4'd0);
      z2 = z1 && (bcd[7:4] == 4'd0);
      commit_code[0] = z0 ? CODE_BLANK : bcd[15:12];
      commit_code[1] = z1 ? CODE_BLANK : bcd[11:8];
      commit_code[2] = z2 ? CODE_BLANK : bcd[7:4];
      commit_code[3] = bcd[3:0];
      if (over) begin
         for (int i = 0; i < 4; i++) commit_code[i] = CODE_DASH;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) dig[i] <= CODE_BLANK;
      end else if (state == COMMIT) begin
         for (int i = 0; i < 4; i++) dig[i] <= commit_code[i];
      end
   end

   // ---------------- glyph lookup ----------------
   logic [4:0]   col5;
   logic [4:0]   col_lo;
   logic [4:0]   col_hi;
   logic [1:0]   sel_idx;
   logic         in_range;
   logic [3:0]   sel_code;
   logic [127:0] glyph;       // line 0 in the top byte

   // 5-bit column bounds so COL0+3 past 15 cannot alias onto low columns.
   assign col5     = {1'b0, char_xy[3:0]};
   assign col_lo   = {1'b0, COL0};
   assign col_hi   = {1'b0, COL0} + 5'd3;
   assign in_range = (char_xy[7:4] == ROW) && (col5 >= col_lo) && (col5 <= col_hi);
   assign sel_idx  = char_xy[1:0] - COL0[1:0];
   assign sel_code = in_range ? dig[sel_idx] : CODE_BLANK;

   // Digit rows are the font_rom entries for ASCII '0'..'9'.
   always_comb begin
      glyph = '0;
      case (sel_code)
         4'd0:    glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
         4'd1:    glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
         4'd2:    glyph = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
         4'd3:    glyph = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
         4'd4:    glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
         4'd5:    glyph = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
         4'd6:    glyph = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
         4'd7:    glyph = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
         4'd8:    glyph = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
         4'd9:    glyph = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
         4'd11:   glyph = 128'h0000_0000_0000_007E_7E00_0000_0000_0000;
         default: glyph = '0;
      endcase
   end

   // Line n sits at bit offset 8*(15-n); for 4-bit n, 15-n equals ~n.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) char_pixel <= 8'h00;
      else      char_pixel <= glyph[{~char_line, 3'b000} +: 8];
   end

endmodule
`default_nettype wire

// File: tb/tb_num_text_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_num_text_responder
// Purpose  : Self-checking bench for num_text_responder. Two instances share
//            stimulus: A (ROW=3, COL0=5, leading blanks) and B (ROW=2,
//            COL0=13, leading zeros, digit 3 falls off column 15).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_num_text_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] value;
   logic        value_valid;
   logic [7:0]  char_xy;
   logic [3:0]  char_line;
   logic        ready_a, ready_b;
   logic [7:0]  pix_a, pix_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [127:0] font_tb [10];
   int           mdig    [2][4];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;
   exp_t exp_q[$];

   logic [7:0] last_a, last_b;

   always #5 clk = ~clk;

   num_text_responder #(.ROW(4'd3), .COL0(4'd5), .LEAD_BLANK(1'b1)) u_dut_a (
      .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
      .value_ready(ready_a), .char_xy(char_xy), .char_line(char_line),
      .char_pixel(pix_a));

   num_text_responder #(.ROW(4'd2), .COL0(4'd13), .LEAD_BLANK(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
      .value_ready(ready_b), .char_xy(char_xy), .char_line(char_line),
      .char_pixel(pix_b));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] glyph_row(int code, logic [3:0] ln);
      logic [127:0] r;
      if (code == 10) return 8'h00;
      if (code == 11) return (ln == 4'd7 || ln == 4'd8) ? 8'h7E : 8'h00;
      r = font_tb[code];
      return r[127 - 8*int'(ln) -: 8];
   endfunction

   function automatic logic [7:0] exp_pix(int inst, logic [7:0] xy, logic [3:0] ln);
      int row = (inst == 0) ? 3 : 2;
      int c0  = (inst == 0) ? 5 : 13;
      int col = int'(xy[3:0]);
      if (int'(xy[7:4]) == row && col >= c0 && col <= c0 + 3)
         return glyph_row(mdig[inst][col - c0], ln);
      return 8'h00;
   endfunction

   task automatic model_blank();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 4; i++) mdig[k][i] = 10;
   endtask

   task automatic model_load(int v);
      int d[4];
      bit lz;
      d[0] = v / 1000; d[1] = (v / 100) % 10; d[2] = (v / 10) % 10; d[3] = v % 10;
      for (int k = 0; k < 2; k++) begin
         if (v > 9999) begin
            for (int i = 0; i < 4; i++) mdig[k][i] = 11;
         end else begin
            lz = 1'b1;
            for (int i = 0; i < 3; i++) begin
               if (d[i] != 0) lz = 1'b0;
               mdig[k][i] = (k == 0 && lz) ? 10 : d[i];
            end
            mdig[k][3] = d[3];
         end
      end
   endtask

   // Let the output register pick up the current display at the held address.
   task automatic refresh_last();
      @(posedge clk); #1;
      last_a = exp_pix(0, char_xy, char_line);
      last_b = exp_pix(1, char_xy, char_line);
      check_eq("refresh_a", {24'd0, pix_a}, {24'd0, last_a});
      check_eq("refresh_b", {24'd0, pix_b}, {24'd0, last_b});
   endtask

   task automatic lookup(input logic [7:0] xy, input logic [3:0] ln);
      exp_t e;
      @(negedge clk);
      char_xy   = xy;
      char_line = ln;
      e.a = exp_pix(0, xy, ln);
      e.b = exp_pix(1, xy, ln);
      exp_q.push_back(e);
      #1;
      // Output must still show the previous lookup until the next edge.
      check_eq("hold_a", {24'd0, pix_a}, {24'd0, last_a});
      check_eq("hold_b", {24'd0, pix_b}, {24'd0, last_b});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check_eq("pix_a", {24'd0, pix_a}, {24'd0, e.a});
      check_eq("pix_b", {24'd0, pix_b}, {24'd0, e.b});
      last_a = e.a;
      last_b = e.b;
   endtask

   task automatic sweep_rows();
      for (int r = 2; r <= 3; r++)
         for (int c = 0; c < 16; c++)
            for (int l = 0; l < 16; l++)
               lookup(8'((r << 4) | c), 4'(l));
   endtask

   // inj: edge index at which a 5555 pulse is presented; rst_at: edge at which reset hits.
   task automatic load(int v, int inj, int rst_at);
      @(negedge clk);
      check_eq("ready_pre_a", {31'd0, ready_a}, 32'd1);
      check_eq("ready_pre_b", {31'd0, ready_b}, 32'd1);
      value       = 14'(v);
      value_valid = 1'b1;
      @(posedge clk); #1;
      value_valid = 1'b0;
      check_eq("ready_e0_a", {31'd0, ready_a}, 32'd0);
      check_eq("ready_e0_b", {31'd0, ready_b}, 32'd0);
      for (int e = 1; e <= 15; e++) begin
         @(negedge clk);
         if (e == inj) begin
            value       = 14'd5555;
            value_valid = 1'b1;
         end
         if (e == rst_at) begin
            rst = 1'b0;
            #1;
            check_eq("rst_ready_a", {31'd0, ready_a}, 32'd1);
            check_eq("rst_ready_b", {31'd0, ready_b}, 32'd1);
            check_eq("rst_pix_a", {24'd0, pix_a}, 32'd0);
            check_eq("rst_pix_b", {24'd0, pix_b}, 32'd0);
            model_blank();
            @(negedge clk);
            rst = 1'b1;
            repeat (12) @(posedge clk);
            refresh_last();
            return;
         end
         @(posedge clk); #1;
         value_valid = 1'b0;
         value       = 14'(v);
         check_eq($sformatf("ready_e%0d_a", e), {31'd0, ready_a}, (e < 15) ? 32'd0 : 32'd1);
         check_eq($sformatf("ready_e%0d_b", e), {31'd0, ready_b}, (e < 15) ? 32'd0 : 32'd1);
      end
      model_load(v);
      refresh_last();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      font_tb[0] = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      font_tb[1] = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      font_tb[2] = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
      font_tb[3] = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
      font_tb[4] = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
      font_tb[5] = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
      font_tb[6] = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
      font_tb[7] = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
      font_tb[8] = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
      font_tb[9] = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
      model_blank();

      rst         = 1'b0;
      value       = '0;
      value_valid = 1'b0;
      char_xy     = 8'h35;
      char_line   = 4'd3;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_ready_a", {31'd0, ready_a}, 32'd1);
      check_eq("reset_ready_b", {31'd0, ready_b}, 32'd1);
      check_eq("reset_pix_a", {24'd0, pix_a}, 32'd0);
      check_eq("reset_pix_b", {24'd0, pix_b}, 32'd0);
      @(negedge clk);
      rst    = 1'b1;
      last_a = 8'h00;
      last_b = 8'h00;

      // Full address/line sweep of the blank post-reset display.
      for (int a = 0; a < 256; a++)
         for (int l = 0; l < 16; l++)
            lookup(8'(a), 4'(l));

      load(42, -1, -1);    sweep_rows();
      load(1234, -1, -1);  sweep_rows();
      load(7, -1, -1);     sweep_rows();
      load(0, -1, -1);     sweep_rows();
      load(12000, -1, -1); sweep_rows();
      load(9999, -1, -1);  sweep_rows();
      load(10000, -1, -1); sweep_rows();
      load(1234, 5, -1);   sweep_rows();
      load(42, -1, -1);
      load(1234, -1, 8);   sweep_rows();
      load(16383, -1, -1); sweep_rows();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
